// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 24-hour packed-BCD time keeper with key-driven hour/minute setting.
// Ports: clk, rst_n (async active-low); tick_1hz advances seconds in RUN;
// key_mode cycles RUN -> SET_HR -> SET_MN -> RUN; key_inc bumps the selected field;
// hr/mn/sd are BCD time, mode is the set state, hour_pulse strobes on each new hour.
module bcd_time_counter #(
  parameter logic [7:0] INIT_HR = 8'h00,
  parameter logic [7:0] INIT_MN = 8'h00,
  parameter logic [7:0] INIT_SD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hr,
  output logic [7:0] mn,
  output logic [7:0] sd,
  output logic [1:0] mode,
  output logic       hour_pulse
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MN = 2'b10, BAD = 2'b11} state_t;
  state_t state, state_n;
  logic [7:0] hr_n, mn_n, sd_n;
  logic tick_run, roll_s, roll_m, hp_n;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction
  assign tick_run = state == RUN && tick_1hz;
  assign roll_s = sd == 8'h59;
  assign roll_m = mn == 8'h59;
  // key_inc is dropped whenever key_mode arrives on the same edge
  always_comb begin
    state_n = state == BAD ? RUN : !key_mode ? state : state == RUN ? SET_HR : state == SET_HR ? SET_MN : RUN;
    sd_n = tick_run ? (roll_s ? 8'h00 : bcd_inc(sd)) : (state == SET_MN && key_mode) ? 8'h00 : sd;
    mn_n = ((tick_run && roll_s) || (state == SET_MN && key_inc && !key_mode)) ? (roll_m ? 8'h00 : bcd_inc(mn)) : mn;
    hr_n = ((tick_run && roll_s && roll_m) || (state == SET_HR && key_inc && !key_mode)) ? (hr == 8'h23 ? 8'h00 : bcd_inc(hr)) : hr;
    hp_n = tick_run && roll_s && roll_m;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      hr <= INIT_HR;
      mn <= INIT_MN;
      sd <= INIT_SD;
      hour_pulse <= 1'b0;
    end else begin
      state <= state_n;
      hr <= hr_n;
      mn <= mn_n;
      sd <= sd_n;
      hour_pulse <= hp_n;
    end
  end
  assign mode = state;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: directed and random checks of bcd_time_counter against a seconds-of-day model.
module tb_bcd_time_counter;
  logic clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0, key_mode = 1'b0, key_inc = 1'b0;
  logic [7:0] hr, mn, sd;
  logic [1:0] mode;
  logic hour_pulse;
  int tests = 0, fails = 0;
  int m_h, m_m, m_s, m_md;
  bit m_hp;
  bcd_time_counter #(.INIT_HR(8'h12), .INIT_MN(8'h34), .INIT_SD(8'h56)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .key_mode(key_mode), .key_inc(key_inc),
    .hr(hr), .mn(mn), .sd(sd), .mode(mode), .hour_pulse(hour_pulse)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("hr", hr, bcd(m_h));
    chk("mn", mn, bcd(m_m));
    chk("sd", sd, bcd(m_s));
    chk("mode", {6'd0, mode}, 8'(m_md));
    chk("hour_pulse", {7'd0, hour_pulse}, {7'd0, m_hp});
  endtask
  task automatic model_reset();
    m_h = 12; m_m = 34; m_s = 56; m_md = 0; m_hp = 0;
  endtask
  // Reference behaviour: time kept as seconds of the day, modes as 0/1/2
  task automatic model_step(input bit km, input bit ki, input bit tk);
    int t;
    m_hp = 0;
    if (m_md == 0 && tk) begin
      t = m_h * 3600 + m_m * 60 + m_s + 1;
      m_hp = (t % 3600) == 0;
      t = t % 86400;
      m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
    end
    if (m_md == 1 && ki && !km) m_h = (m_h + 1) % 24;
    if (m_md == 2 && ki && !km) m_m = (m_m + 1) % 60;
    if (m_md == 2 && km) m_s = 0;
    if (km) m_md = (m_md + 1) % 3;
  endtask
  task automatic step(input bit km, input bit ki, input bit tk);
    key_mode = km; key_inc = ki; tick_1hz = tk;
    @(posedge clk);
    model_step(km, ki, tk);
    @(negedge clk);
    key_mode = 1'b0; key_inc = 1'b0; tick_1hz = 1'b0;
    check_all();
  endtask
  // From RUN: set hours and minutes, return to RUN with seconds at 00
  task automatic set_time(input int h, input int m);
    step(1, 0, 0);
    for (int i = 0; i < 24 && m_h != h; i++) step(0, 1, 0);
    step(1, 0, 0);
    for (int i = 0; i < 60 && m_m != m; i++) step(0, 1, 0);
    step(1, 0, 0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step(0, 0, 0);
    set_time(9, 9);
    ticks(9);
    ticks(1);
    set_time(9, 59);
    ticks(59);
    ticks(1);
    step(0, 0, 0);
    set_time(23, 59);
    ticks(59);
    ticks(1);
    step(0, 0, 0);
    ticks(5);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 24 && m_h != 23; i++) step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    set_time(5, 59);
    ticks(33);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 1);
    step(1, 0, 0);
    ticks(1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
    set_time(12, 59);
    ticks(59);
    for (int i = 0; i < 60; i++) step(0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day source for the clock top level. It keeps a 24-hour time in packed BCD from a 1 Hz enable pulse and lets the user set hours and minutes with two pre-debounced key pulses. Its hr/mn/sd outputs drive the display path and the hourly-chime logic, which reads these buses directly. It also supplies a single-cycle top-of-hour strobe to downstream logic.

## Interface
- INIT_HR, 8'h00, reset value of hr; packed BCD, must be legal (00–23)
- INIT_MN, 8'h00, reset value of mn; packed BCD, must be legal (00–59)
- INIT_SD, 8'h00, reset value of sd; packed BCD, must be legal (00–59)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle enable pulse, once per second
- key_mode  in  1  one-cycle pulse, already debounced; advances the set mode
- key_inc  in  1  one-cycle pulse, already debounced; increments the field selected by mode
- hr  out  8  hours, packed BCD, 00–23
- mn  out  8  minutes, packed BCD, 00–59
- sd  out  8  seconds, packed BCD, 00–59
- mode  out  2  00 = RUN, 01 = SET_HR, 10 = SET_MN
- hour_pulse  out  1  one-cycle strobe on the 59:59 -> 00:00 rollover

## Operation
- All outputs are registered.
- Reset values: hr = INIT_HR, mn = INIT_MN, sd = INIT_SD, mode = 00, hour_pulse = 0.
- Mode FSM, advanced by key_mode:
  - RUN -> SET_HR -> SET_MN -> RUN.
  - Encoding 11 is unreachable; if entered, go to RUN on the next clock.
- Actions use the state at the current edge:
  - On the edge where key_mode is high, key_inc is ignored.
  - On that same edge, tick_1hz is still applied if the current state is RUN.
- BCD increment of a field:
  - If the low nibble is 9, it becomes 0 and the high nibble increments.
  - Otherwise the low nibble increments.
  - Wrap compares use equality against 8'h59 (minutes/seconds) and 8'h23 (hours).
- RUN:
  - tick_1hz high: sd increments; sd == 59 -> 00 with carry into mn.
  - On carry: mn == 59 -> 00 with carry into hr.
  - On carry: hr == 23 -> 00.
  - All carries resolve on the same edge; no intermediate values are visible.
  - key_inc is ignored.
- SET_HR:
  - tick_1hz is ignored; the time is frozen.
  - key_inc: hr increments, 23 -> 00; no effect on other fields.
- SET_MN:
  - tick_1hz is ignored.
  - key_inc: mn increments, 59 -> 00; no carry into hr.
- Leaving SET_MN for RUN: sd is cleared to 00 on the same edge, so the set time is committed at :00.
- hour_pulse:
  - Asserted for exactly one cycle, on the edge where a RUN tick rolls both mn and sd from 59 to 00. This includes 23:59:59 -> 00:00:00.
  - Never asserted by set-mode increments.
- Reset mid-operation (any state, any field value) forces the reset values immediately, asynchronously.

## Timing
- Latency: fields update on the same rising edge that samples tick_1hz or key_inc high. New values are visible one cycle after the pulse.
- mode changes on the edge sampling key_mode. The next key_inc acts on the new field.
- hour_pulse is high during the cycle in which hr/mn/sd first show the new hour.
- Back-to-back key_inc pulses (every cycle) each increment once; no rate limit.
- tick_1hz held high for N cycles in RUN advances N seconds. Upstream guarantees one-cycle pulses.

## Test plan
- Reset with INIT_HR = 8'h12, INIT_MN = 8'h34, INIT_SD = 8'h56 -> outputs 12:34:56, mode = 00, hour_pulse = 0. Pulse rst_n low mid-SET_MN -> same values, mode = 00.
- RUN at 09:09:09, one tick -> 09:09:10. At 09:59:59, one tick -> 10:00:00 with hour_pulse high exactly one cycle. At 23:59:59, one tick -> 00:00:00 with hour_pulse.
- key_mode -> mode = 01. Ticks during SET_HR leave time unchanged. key_inc from hr = 23 -> hr = 00, mn and sd unchanged.
- Mode 10 at 05:59:33:
  - key_inc -> 05:00:33; hr is not incremented and hour_pulse stays 0.
  - key_mode -> mode = 00 and sd = 00.
  - Next tick -> 05:00:01.
- key_mode and key_inc in the same cycle in SET_HR -> mode = 10, hr unchanged.
- key_mode and tick in the same cycle in RUN at 00:00:05 -> mode = 01, sd = 06.
